// File: rtl/pmem_pkg.sv
// Shared widths, controller state encoding and TTM4 instruction layout for the
// program-memory controller.
package pmem_pkg;

   localparam int ADDR_W = 8;
   localparam int WORD_W = 16;
   localparam int CNT_W  = 8;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR_SU,
      WR_PL,
      WR_HD,
      VF_RD,
      ACK
   } pmem_state_e;

   // TTM4 instruction word as stored in the SRAM pair; bit 15 is reserved.
   typedef struct packed {
      logic       rsvd;
      logic [4:0] op;
      logic [2:0] sr;
      logic [2:0] lr;
      logic [3:0] im;
   } pmem_instr_t;

endpackage

// File: rtl/pmem_phase_cnt.sv
// Loadable down-counter timing every strobe phase of the controller; tc is high
// while the count is zero, i.e. during the last cycle of the loaded phase.
module pmem_phase_cnt
   import pmem_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/pmem_ctrl.sv
// TTM4 program-memory sequencer/arbiter: shares the SRAM pair between CPU fetch
// and host load. Define PMEM_WRITE_VERIFY_EN to add a read-back check after writes.
module pmem_ctrl
   import pmem_pkg::*;
#(
   parameter int RD_WAIT  = 2,
   parameter int WR_SETUP = 1,
   parameter int WR_PULSE = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              FETCH_REQ,
   input  logic [ADDR_W-1:0] FETCH_ADD,
   output logic              FETCH_ACK,
   output logic [WORD_W-1:0] FETCH_DATA,
   input  logic              LOAD_REQ,
   input  logic [ADDR_W-1:0] LOAD_ADD,
   input  logic [WORD_W-1:0] LOAD_DATA,
   output logic              LOAD_ACK,
   output logic              LOAD_ERR,
   output logic              BUSY,
   output logic [ADDR_W-1:0] MEM_ADD,
   output logic              MEM_nOE,
   output logic              MEM_nWE,
   output logic [WORD_W-1:0] MEM_DOUT,
   output logic              MEM_DOE,
   input  logic [WORD_W-1:0] MEM_DIN
);

   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
   localparam logic [CNT_W-1:0] SU_LOAD = CNT_W'(WR_SETUP - 1);
   localparam logic [CNT_W-1:0] PL_LOAD = CNT_W'(WR_PULSE - 1);

   pmem_state_e       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic [WORD_W-1:0] fetch_data_q, fetch_data_d;
   logic              fetch_ack_q, fetch_ack_d;
   logic              load_ack_q, load_ack_d;
   logic              noe_q, noe_d;
   logic              nwe_q, nwe_d;
   logic              doe_q, doe_d;
   logic              cnt_load;
   logic [CNT_W-1:0]  cnt_val;
   logic              cnt_tc;
`ifdef PMEM_WRITE_VERIFY_EN
   logic              load_err_q, load_err_d;
`endif

   pmem_phase_cnt u_phase_cnt (
      .clk      (CLK),
      .rst      (RST),
      .load     (cnt_load),
      .load_val (cnt_val),
      .tc       (cnt_tc)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      data_d       = data_q;
      fetch_data_d = fetch_data_q;
      fetch_ack_d  = 1'b0;
      load_ack_d   = 1'b0;
      cnt_load     = 1'b0;
      cnt_val      = '0;
`ifdef PMEM_WRITE_VERIFY_EN
      load_err_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (LOAD_REQ) begin
               addr_d   = LOAD_ADD;
               data_d   = LOAD_DATA;
               cnt_load = 1'b1;
               cnt_val  = SU_LOAD;
               state_d  = WR_SU;
            end else if (FETCH_REQ) begin
               addr_d   = FETCH_ADD;
               cnt_load = 1'b1;
               cnt_val  = RD_LOAD;
               state_d  = RD;
            end
         end
         RD: begin
            if (cnt_tc) begin
               fetch_data_d = MEM_DIN;
               fetch_ack_d  = 1'b1;
               state_d      = ACK;
            end
         end
         WR_SU: begin
            if (cnt_tc) begin
               cnt_load = 1'b1;
               cnt_val  = PL_LOAD;
               state_d  = WR_PL;
            end
         end
         WR_PL: begin
            if (cnt_tc) begin
               state_d = WR_HD;
            end
         end
         WR_HD: begin
`ifdef PMEM_WRITE_VERIFY_EN
            cnt_load = 1'b1;
            cnt_val  = RD_LOAD;
            state_d  = VF_RD;
`else
            load_ack_d = 1'b1;
            state_d    = ACK;
`endif
         end
`ifdef PMEM_WRITE_VERIFY_EN
         VF_RD: begin
            if (cnt_tc) begin
               load_ack_d = 1'b1;
               load_err_d = (MEM_DIN != data_q);
               state_d    = ACK;
            end
         end
`endif
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Strobes are decoded from the next state so they leave the flops glitch-free.
      noe_d = !((state_d == RD) || (state_d == VF_RD));
      nwe_d = (state_d != WR_PL);
      doe_d = (state_d == WR_SU) || (state_d == WR_PL) || (state_d == WR_HD);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         data_q       <= '0;
         fetch_data_q <= '0;
         fetch_ack_q  <= 1'b0;
         load_ack_q   <= 1'b0;
         noe_q        <= 1'b1;
         nwe_q        <= 1'b1;
         doe_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         fetch_data_q <= fetch_data_d;
         fetch_ack_q  <= fetch_ack_d;
         load_ack_q   <= load_ack_d;
         noe_q        <= noe_d;
         nwe_q        <= nwe_d;
         doe_q        <= doe_d;
      end
   end

`ifdef PMEM_WRITE_VERIFY_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         load_err_q <= 1'b0;
      end else begin
         load_err_q <= load_err_d;
      end
   end

   assign LOAD_ERR = load_err_q;
`else
   assign LOAD_ERR = 1'b0;
`endif

   assign FETCH_ACK  = fetch_ack_q;
   assign FETCH_DATA = fetch_data_q;
   assign LOAD_ACK   = load_ack_q;
   assign BUSY       = (state_q != IDLE);
   assign MEM_ADD    = addr_q;
   assign MEM_DOUT   = data_q;
   assign MEM_nOE    = noe_q;
   assign MEM_nWE    = nwe_q;
   assign MEM_DOE    = doe_q;

endmodule

// File: tb/tb_pmem_ctrl.sv
// Bench for pmem_ctrl: a transaction-timeline model checked every cycle plus
// directed scenarios with literal expectations. Follows PMEM_WRITE_VERIFY_EN.
module tb_pmem_ctrl;

   localparam int RD_WAIT  = 2;
   localparam int WR_SETUP = 1;
   localparam int WR_PULSE = 2;
`ifdef PMEM_WRITE_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif
   localparam int RD_LEN = RD_WAIT;
   localparam int WR_LEN = WR_SETUP + WR_PULSE + 1 + (VERIFY ? RD_WAIT : 0);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req, load_req;
   logic [7:0]  fetch_add, load_add;
   logic [15:0] load_data;
   logic        fetch_ack, load_ack, load_err, busy;
   logic [15:0] fetch_data, mem_dout, mem_din;
   logic [7:0]  mem_add;
   logic        mem_noe, mem_nwe, mem_doe;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   pmem_ctrl #(
      .RD_WAIT  (RD_WAIT),
      .WR_SETUP (WR_SETUP),
      .WR_PULSE (WR_PULSE)
   ) dut (
      .CLK        (clk),
      .RST        (rst),
      .FETCH_REQ  (fetch_req),
      .FETCH_ADD  (fetch_add),
      .FETCH_ACK  (fetch_ack),
      .FETCH_DATA (fetch_data),
      .LOAD_REQ   (load_req),
      .LOAD_ADD   (load_add),
      .LOAD_DATA  (load_data),
      .LOAD_ACK   (load_ack),
      .LOAD_ERR   (load_err),
      .BUSY       (busy),
      .MEM_ADD    (mem_add),
      .MEM_nOE    (mem_noe),
      .MEM_nWE    (mem_nwe),
      .MEM_DOUT   (mem_dout),
      .MEM_DOE    (mem_doe),
      .MEM_DIN    (mem_din)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] initWord(input int i);
      logic [7:0] b;
      b = 8'(i);
      if (i == 16'h10) return 16'h1234;
      return {b ^ 8'h5A, b};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // SRAM pair: latches on the rising nWE edge while data is driven, optional bit-3 fault.
   logic [15:0] sram [256];
   bit          mem_init = 1'b0;
   bit          corrupt  = 1'b0;
   logic        prev_nwe = 1'b1;
   int          noe_cnt = 0, nwe_cnt = 0, doe_cnt = 0, bad_cnt = 0;

   always @(negedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) sram[i] = initWord(i);
         mem_init = 1'b1;
      end
      if (mem_nwe === 1'b1 && prev_nwe === 1'b0 && mem_doe === 1'b1)
         sram[mem_add] = corrupt ? (mem_dout ^ 16'h0008) : mem_dout;
      prev_nwe = mem_nwe;
      if (mem_noe === 1'b0) noe_cnt++;
      if (mem_nwe === 1'b0) nwe_cnt++;
      if (mem_doe === 1'b1) doe_cnt++;
      if ((mem_doe === 1'b1 || mem_nwe === 1'b0) && (mem_add !== load_add || mem_dout !== load_data))
         bad_cnt++;
   end

   assign mem_din = (mem_noe === 1'b0) ? sram[mem_add] : 16'hDEAD;

   // Timeline model: m_off counts cycles since the accept edge of the current transaction.
   bit          m_valid = 1'b0, m_busy = 1'b0, m_wr = 1'b0, m_corrupt = 1'b0, m_err = 1'b0;
   int          m_off = 0;
   logic [7:0]  m_addr = '0;
   logic [15:0] m_dout = '0, m_fdata = '0;
   logic [15:0] shadow [256];
   bit          shadow_init = 1'b0;

   always @(posedge clk) begin
      int len;
      cyc++;
      if (!shadow_init) begin
         for (int i = 0; i < 256; i++) shadow[i] = initWord(i);
         shadow_init = 1'b1;
      end
      len = m_wr ? WR_LEN : RD_LEN;
      if (rst) begin
         m_valid = 1'b1;
         m_busy  = 1'b0;
         m_off   = 0;
         m_addr  = '0;
         m_dout  = '0;
         m_fdata = '0;
         m_err   = 1'b0;
      end else if (m_busy) begin
         m_off++;
         if (m_off == len + 1) begin
            if (m_wr) begin
               shadow[m_addr] = m_corrupt ? (m_dout ^ 16'h0008) : m_dout;
               m_err = VERIFY && (shadow[m_addr] != m_dout);
            end else begin
               m_fdata = shadow[m_addr];
            end
         end
         if (m_off > len + 1) m_busy = 1'b0;
      end else if (load_req) begin
         m_busy    = 1'b1;
         m_wr      = 1'b1;
         m_off     = 1;
         m_addr    = load_add;
         m_dout    = load_data;
         m_corrupt = corrupt;
      end else if (fetch_req) begin
         m_busy = 1'b1;
         m_wr   = 1'b0;
         m_off  = 1;
         m_addr = fetch_add;
      end
   end

   bit c_rd, c_wr, c_drv, c_ack;
   int c_len;

   always @(negedge clk) begin
      if (m_valid) begin
         c_len = m_wr ? WR_LEN : RD_LEN;
         c_rd  = m_busy && ((!m_wr && m_off <= RD_WAIT) ||
                 (m_wr && VERIFY && m_off >= WR_SETUP + WR_PULSE + 2 && m_off <= WR_LEN));
         c_wr  = m_busy && m_wr && m_off >= WR_SETUP + 1 && m_off <= WR_SETUP + WR_PULSE;
         c_drv = m_busy && m_wr && m_off <= WR_SETUP + WR_PULSE + 1;
         c_ack = m_busy && (m_off == c_len + 1);
         checkOutput("busy", busy, m_busy);
         checkOutput("mem_noe", mem_noe, !c_rd);
         checkOutput("mem_nwe", mem_nwe, !c_wr);
         checkOutput("mem_doe", mem_doe, c_drv);
         checkOutput("fetch_ack", fetch_ack, c_ack && !m_wr);
         checkOutput("load_ack", load_ack, c_ack && m_wr);
         checkOutput("load_err", load_err, c_ack && m_wr && m_err);
         checkOutput("fetch_data", fetch_data, m_fdata);
         checkOutput("mem_add", mem_add, m_addr);
         checkOutput("mem_dout", mem_dout, m_dout);
         checkOutput("strobe_excl", mem_noe | mem_nwe, 1'b1);
         checkOutput("doe_vs_noe", mem_doe & ~mem_noe, 1'b0);
      end
   end

   int r_ld_lat, r_fe_lat, r_ld_acks, r_fe_acks, r_noe, r_nwe, r_doe, r_bad;
   bit r_err;

   // Raise the requested transactions together, drop each request after its ACK, observe 20 cycles.
   task automatic applyStimulus(input bit do_ld, input bit do_fe, input logic [7:0] la,
                                input logic [15:0] ld, input logic [7:0] fa);
      int t0, n_noe, n_nwe, n_doe, n_bad;
      @(negedge clk);
      #1;
      t0 = cyc;
      n_noe = noe_cnt; n_nwe = nwe_cnt; n_doe = doe_cnt; n_bad = bad_cnt;
      load_add = la; load_data = ld; fetch_add = fa;
      load_req = do_ld; fetch_req = do_fe;
      r_ld_lat = -1; r_fe_lat = -1; r_ld_acks = 0; r_fe_acks = 0; r_err = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (load_ack === 1'b1) begin
            r_ld_acks++;
            r_err = load_err;
            if (r_ld_lat < 0) r_ld_lat = cyc - t0;
         end
         if (fetch_ack === 1'b1) begin
            r_fe_acks++;
            if (r_fe_lat < 0) r_fe_lat = cyc - t0;
         end
         #1;
         if (r_ld_acks > 0) load_req = 1'b0;
         if (r_fe_acks > 0) fetch_req = 1'b0;
      end
      load_req = 1'b0;
      fetch_req = 1'b0;
      r_noe = noe_cnt - n_noe; r_nwe = nwe_cnt - n_nwe;
      r_doe = doe_cnt - n_doe; r_bad = bad_cnt - n_bad;
   endtask

   initial begin
      int t0, a1, a2, n_acks;
      bit seen;
      fetch_req = 1'b0; load_req = 1'b0;
      fetch_add = '0; load_add = '0; load_data = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_fetch_ack", fetch_ack, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_nOE", mem_noe, 1'b1);
      checkOutput("rst_nWE", mem_nwe, 1'b1);
      checkOutput("rst_DOE", mem_doe, 1'b0);
      checkOutput("rst_fetch_data", fetch_data, 16'h0000);
      #1 rst = 1'b0;

      $display("[TB] single fetch 0x10");
      applyStimulus(1'b0, 1'b1, 8'h00, 16'h0000, 8'h10);
      checkOutput("rd_acks", r_fe_acks, 1);
      checkOutput("rd_latency", r_fe_lat, 3);
      checkOutput("rd_data", fetch_data, 16'h1234);
      checkOutput("rd_noe_cycles", r_noe, 2);
      checkOutput("rd_nwe_cycles", r_nwe, 0);

      $display("[TB] single load 0x05");
      applyStimulus(1'b1, 1'b0, 8'h05, 16'hABCD, 8'h00);
      checkOutput("wr_acks", r_ld_acks, 1);
      checkOutput("wr_latency", r_ld_lat, VERIFY ? 7 : 5);
      checkOutput("wr_nwe_cycles", r_nwe, 2);
      checkOutput("wr_doe_cycles", r_doe, 4);
      checkOutput("wr_addr_data_stable", r_bad, 0);
      checkOutput("wr_err", r_err, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h00, 16'h0000, 8'h05);
      checkOutput("rd_after_wr", fetch_data, 16'hABCD);

      $display("[TB] simultaneous load and fetch");
      applyStimulus(1'b1, 1'b1, 8'h20, 16'h5A5A, 8'h20);
      checkOutput("both_load_acks", r_ld_acks, 1);
      checkOutput("both_fetch_acks", r_fe_acks, 1);
      checkOutput("both_load_lat", r_ld_lat, VERIFY ? 7 : 5);
      checkOutput("both_fetch_lat", r_fe_lat, VERIFY ? 11 : 9);
      checkOutput("both_fetch_data", fetch_data, 16'h5A5A);

      $display("[TB] reset during write pulse");
      @(negedge clk);
      #1;
      load_add = 8'h30; load_data = 16'hFFFF; load_req = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (mem_nwe === 1'b0) seen = 1'b1;
      end
      checkOutput("abort_reached_pulse", seen, 1'b1);
      #1;
      rst = 1'b1;
      load_req = 1'b0;
      @(negedge clk);
      checkOutput("abort_nWE", mem_nwe, 1'b1);
      checkOutput("abort_DOE", mem_doe, 1'b0);
      checkOutput("abort_load_ack", load_ack, 1'b0);
      checkOutput("abort_busy", busy, 1'b0);
      #1 rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 8'h00, 16'h0000, 8'h30);
      checkOutput("post_abort_acks", r_fe_acks, 1);
      checkOutput("post_abort_lat", r_fe_lat, 3);
      checkOutput("post_abort_data", fetch_data, 16'h6A30);

      $display("[TB] back-to-back fetches with request held");
      @(negedge clk);
      #1;
      fetch_add = 8'h11; fetch_req = 1'b1;
      t0 = cyc; a1 = -1; a2 = -1; n_acks = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (fetch_ack === 1'b1) begin
            n_acks++;
            if (a1 < 0) a1 = cyc;
            else if (a2 < 0) a2 = cyc;
         end
         #1;
         if (a2 >= 0) fetch_req = 1'b0;
      end
      fetch_req = 1'b0;
      checkOutput("b2b_acks", n_acks, 2);
      checkOutput("b2b_first_lat", a1 - t0, 3);
      checkOutput("b2b_ack_gap", a2 - a1, 4);
      checkOutput("b2b_data", fetch_data, 16'h4B11);

      $display("[TB] write with faulty memory bit 3");
      corrupt = 1'b1;
      applyStimulus(1'b1, 1'b0, 8'h40, 16'h00F0, 8'h00);
      checkOutput("bad_wr_acks", r_ld_acks, 1);
      checkOutput("bad_wr_err", r_err, VERIFY ? 1'b1 : 1'b0);
      corrupt = 1'b0;
      applyStimulus(1'b1, 1'b0, 8'h41, 16'h0F0F, 8'h00);
      checkOutput("good_wr_err", r_err, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h00, 16'h0000, 8'h40);
      checkOutput("bad_wr_readback", fetch_data, 16'h00F8);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/pmem_ctrl.md
# pmem_ctrl

Sequencer and arbiter for the TTM4 program memory (two 8-bit async SRAMs forming one 16-bit instruction word at an 8-bit address). Shares the memory between the CPU instruction-fetch port and the host program-load port. Generates the nOE/nWE strobes with programmable setup, pulse and hold phases. Sits between the CPU core / loader and the SRAM pair inside the emulator top.

## Interface
- RD_WAIT, 2, cycles nOE held low before read data is sampled (≥1)
- WR_SETUP, 1, cycles address/data driven before nWE falls (≥1)
- WR_PULSE, 2, cycles nWE held low (≥1)

- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- FETCH_REQ  in  1  CPU read request; held until FETCH_ACK
- FETCH_ADD  in  8  CPU read address
- FETCH_ACK  out  1  one-cycle pulse: FETCH_DATA valid
- FETCH_DATA  out  16  registered instruction word
- LOAD_REQ  in  1  host write request; held until LOAD_ACK
- LOAD_ADD  in  8  host write address
- LOAD_DATA  in  16  host write word
- LOAD_ACK  out  1  one-cycle pulse: write complete
- LOAD_ERR  out  1  valid with LOAD_ACK; readback mismatch
- BUSY  out  1  high when state ≠ IDLE
- MEM_ADD  out  8  SRAM address (both devices)
- MEM_nOE  out  1  SRAM output enable, active-low
- MEM_nWE  out  1  SRAM write enable, active-low
- MEM_DOUT  out  16  write data; [7:0] SRAM1, [15:8] SRAM2
- MEM_DOE  out  1  tristate drive enable for MEM_DOUT
- MEM_DIN  in  16  read data from SRAM pair

## Operation
- States: IDLE, RD, WR_SU, WR_PL, WR_HD, VF_RD (verify only), ACK.
- IDLE: LOAD_REQ wins over FETCH_REQ when both high. Accept latches address (and data) into registers.
- RD: MEM_ADD=addr, nOE=0 for RD_WAIT cycles. On last cycle edge: FETCH_DATA<=MEM_DIN, FETCH_ACK<=1, nOE<=1, go to ACK.
- WR_SU: DOE=1, nWE=1, WR_SETUP cycles. WR_PL: nWE=0, WR_PULSE cycles. WR_HD: nWE=1, DOE=1, 1 cycle. Then LOAD_ACK<=1, go to ACK (or VF_RD when verify is compiled in).
- ACK: one turnaround cycle, ACK pulse high, no request accepted. Then IDLE.
- Invariants: nOE and nWE never both low. DOE=0 whenever nOE=0. MEM_ADD and MEM_DOUT stable across the whole nWE-low window.
- FETCH_DATA holds its last value between reads.
- Address registers are 8-bit, no wrap logic needed. Full 0x00–0xFF range accessible.

## Timing
- Request accepted in cycle T (IDLE, REQ high). Strobes begin in cycle T+1.
- Read: nOE low T+1..T+RD_WAIT. FETCH_ACK high in T+RD_WAIT+1. Next accept no earlier than T+RD_WAIT+2.
- Write: nWE low T+1+WR_SETUP..T+WR_SETUP+WR_PULSE. LOAD_ACK high in T+WR_SETUP+WR_PULSE+2.
- Reset values: FETCH_ACK=0, LOAD_ACK=0, LOAD_ERR=0, BUSY=0, FETCH_DATA=0, MEM_ADD=0, MEM_DOUT=0, MEM_nOE=1, MEM_nWE=1, MEM_DOE=0. State is IDLE.
- RST mid-transaction: values above take effect at the next edge. The in-flight transaction is dropped with no ACK. The requester must re-issue.
- A REQ dropped before its ACK is protocol violation. The transaction still completes.

## Configuration
- PMEM_WRITE_VERIFY_EN defined:
  - After WR_HD, enter VF_RD (DOE=0, nOE=0 for RD_WAIT cycles), then compare MEM_DIN with the latched data.
  - LOAD_ACK and LOAD_ERR (1 on mismatch) assert together in the following cycle.
  - Write latency grows by RD_WAIT.
- Undefined: no VF_RD state. LOAD_ERR is tied 0.

## Structure
- pmem_pkg holds:
  - ADDR_W=8, WORD_W=16.
  - State enumeration.
  - Instruction field slices: IM [3:0], LR [6:4], SR [9:7], OP [14:10]; bit 15 reserved.
- One sub-module, pmem_phase_cnt: loadable down-counter with a terminal-count flag, shared by all timed phases.

## Test plan
- Reset then FETCH_REQ, FETCH_ADD=0x10, MEM_DIN=0x1234 (RD_WAIT=2) -> nOE low 2 cycles, FETCH_ACK in cycle T+3, FETCH_DATA=0x1234.
- LOAD_REQ with ADD=0x05, DATA=0xABCD (defaults) -> nWE low exactly 2 cycles, DOE=1 from T+1 through hold, LOAD_ACK at T+5, MEM_ADD=0x05 throughout.
- FETCH_REQ and LOAD_REQ raised in the same cycle -> write served first, then read. Exactly one ACK of each.
- RST asserted during WR_PL -> next cycle nWE=1, DOE=0, no LOAD_ACK. Fresh request accepted after RST falls.
- Verify build: memory model corrupts bit 3 on write -> LOAD_ACK with LOAD_ERR=1. Clean write gives LOAD_ERR=0.
- Back-to-back fetches with REQ held high -> one idle turnaround cycle between ACKs. nOE/nWE are never both low (assertion).
